noekeon_round_ctrl: RTL and testbench

NOEKEON_ROUND_CTRL -- requirements
Module: noekeon_round_ctrl

---
 rtl/noekeon_pkg.sv | 19 +
 rtl/noekeon_round_ctrl_if.sv | 28 ++
 rtl/noekeon_rcon_gen.sv | 38 +++
 rtl/noekeon_round_ctrl.sv | 87 ++++++++
 tb/tb_noekeon_round_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/noekeon_pkg.sv
// Shared types and constants for the Noekeon round controller.
// Round-constant values are the GF(2^8) sequence generated by x^8+x^4+x^3+x+1.
package noekeon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          NOEKEON_ROUNDS = 16;
  localparam logic [7:0]  RCON_INIT      = 8'h80;
  localparam logic [7:0]  RCON_LAST      = 8'hD4;
  localparam logic [7:0]  RCON_POLY      = 8'h1B;
  localparam logic [7:0]  RCON_IPOLY     = 8'h8D;

endpackage

// File: rtl/noekeon_round_ctrl_if.sv
// Control bus between the round controller and its client/datapath.
// Handshake: a block is accepted on a rising edge where inStart=1 and outReady=1;
// outDone pulses for exactly one cycle when the datapath result is valid.
interface noekeon_round_ctrl_if;
  logic       inStart;
  logic       inDecipher;
  logic       inAbort;
  logic       outReady;
  logic       outLoad;
  logic       outKeyDecipher;
  logic       outRoundEn;
  logic       outFinal;
  logic [7:0] outRcon;
  logic [4:0] outRound;
  logic       outDone;

  modport master (
    output inStart, inDecipher, inAbort,
    input  outReady, outLoad, outKeyDecipher, outRoundEn, outFinal,
           outRcon, outRound, outDone
  );

  modport slave (
    input  inStart, inDecipher, inAbort,
    output outReady, outLoad, outKeyDecipher, outRoundEn, outFinal,
           outRcon, outRound, outDone
  );
endinterface

// File: rtl/noekeon_rcon_gen.sv
// Round-constant register: seeded with the first constant of the chosen
// direction, then stepped forward (xtime) or backward (inverse xtime).
module noekeon_rcon_gen
  import noekeon_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_en,
  input  logic       seed_dec,
  input  logic       step_en,
  input  logic       step_inv,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (seed_en) begin
      rcon_d = seed_dec ? RCON_LAST : RCON_INIT;
    end else if (step_en) begin
      if (step_inv) begin
        rcon_d = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? RCON_IPOLY : 8'h00);
      end else begin
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? RCON_POLY : 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rcon_q <= 8'h00;
    else        rcon_q <= rcon_d;
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/noekeon_round_ctrl.sv
// Sequencer for an iterative Noekeon datapath: LOAD, 16 ROUND cycles, FINAL, DONE.
// Every output is decoded from registered state so nothing on the bus is input-combinational.
module noekeon_round_ctrl
  import noekeon_pkg::*;
#(
  parameter int ROUNDS = NOEKEON_ROUNDS
) (
  input  logic                 inClk,
  input  logic                 inRstN,
  noekeon_round_ctrl_if.slave  bus,
  output state_e               outState
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic       seed_en;
  logic       step_en;
  logic [7:0] rcon;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    seed_en = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.inStart) begin
          state_d = ST_LOAD;
          mode_d  = bus.inDecipher;
        end
      end
      ST_LOAD: begin
        seed_en = 1'b1;
        cnt_d   = 4'd0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        step_en = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'(ROUNDS - 1)) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort only cancels work in flight; DONE already returns to IDLE.
    if (bus.inAbort && (state_q inside {ST_LOAD, ST_ROUND, ST_FINAL})) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  noekeon_rcon_gen u_rcon (
    .clk      (inClk),
    .rst_n    (inRstN),
    .seed_en  (seed_en),
    .seed_dec (mode_q),
    .step_en  (step_en),
    .step_inv (mode_q),
    .rcon     (rcon)
  );

  assign bus.outReady       = (state_q == ST_IDLE);
  assign bus.outLoad        = (state_q == ST_LOAD);
  assign bus.outKeyDecipher = mode_q;
  assign bus.outRoundEn     = (state_q == ST_ROUND);
  assign bus.outFinal       = (state_q == ST_FINAL);
  assign bus.outDone        = (state_q == ST_DONE);
  assign bus.outRcon        = (state_q == ST_ROUND || state_q == ST_FINAL) ? rcon : 8'h00;
  assign bus.outRound       = (state_q == ST_ROUND) ? {1'b0, cnt_q} :
                              (state_q == ST_FINAL) ? 5'(ROUNDS) : 5'd0;
  assign outState           = state_q;

endmodule

// File: tb/tb_noekeon_round_ctrl.sv
// Directed bench for noekeon_round_ctrl: expected per-cycle bus records are
// queued by the driver and consumed by a negedge monitor.
module tb_noekeon_round_ctrl;
  import noekeon_pkg::*;

  // clock / reset
  logic   inClk = 1'b0;
  logic   inRstN = 1'b0;
  state_e st;
  always #5 inClk = ~inClk;

  noekeon_round_ctrl_if bus ();

  noekeon_round_ctrl #(.ROUNDS(16)) dut (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .bus      (bus),
    .outState (st)
  );

  // Hand-computed constant tables.
  logic [7:0] enc_tab [16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                               8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A};
  logic [7:0] dec_tab [16] = '{8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E,
                               8'h2F, 8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B};

  // scoreboard
  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  function automatic logic [17:0] rec(bit ld, bit re, bit fi, bit dn, bit kd,
                                      logic [7:0] rc, logic [4:0] rn);
    return {ld, re, fi, dn, kd, rc, rn};
  endfunction

  task automatic push_op(input bit dec, input int n_rec);
    logic [17:0] r [19];
    r[0] = rec(1, 0, 0, 0, dec, 8'h00, 5'd0);
    for (int i = 0; i < 16; i++)
      r[i+1] = rec(0, 1, 0, 0, dec, dec ? dec_tab[i] : enc_tab[i], 5'(i));
    r[17] = rec(0, 0, 1, 0, dec, dec ? 8'h80 : 8'hD4, 5'd16);
    r[18] = rec(0, 0, 0, 1, dec, 8'h00, 5'd0);
    for (int i = 0; i < n_rec; i++) exp_q.push_back(r[i]);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor
  always @(negedge inClk) begin
    logic [17:0] got;
    logic [17:0] e;
    got = {bus.outLoad, bus.outRoundEn, bus.outFinal, bus.outDone,
           bus.outKeyDecipher, bus.outRcon, bus.outRound};
    if (bus.outDone) done_cnt++;
    if (bus.outLoad || bus.outRoundEn || bus.outFinal || bus.outDone) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%h exp=<none>", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_trace got=%h exp=%h", got, e);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    inRstN = 1'b0;
    bus.inStart = 1'b0; bus.inDecipher = 1'b0; bus.inAbort = 1'b0;
    repeat (2) @(posedge inClk);
    #1 inRstN = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, 32'(bus.outReady), 32'd1);
    check({name, "_outs"}, {bus.outLoad, bus.outRoundEn, bus.outFinal, bus.outDone,
                            bus.outRcon, bus.outRound}, 32'd0);
    check({name, "_state"}, 32'(st), 32'(ST_IDLE));
  endtask

  // Start sampled on the next edge ("edge 0"); returns #1 after it, in cycle 1.
  task automatic start_op(input bit dec, input bit abort_too);
    @(negedge inClk);
    bus.inStart = 1'b1; bus.inDecipher = dec; bus.inAbort = abort_too;
    @(posedge inClk);
    #1 bus.inStart = 1'b0; bus.inAbort = 1'b0;
  endtask

  task automatic run_full(input string name, input bit dec, input bit abort_too,
                          input bit toggle);
    int c;
    int d0;
    bit seen;
    d0 = done_cnt;
    push_op(dec, 19);
    start_op(dec, abort_too);
    c = 1;
    seen = 0;
    while (c < 40 && !seen) begin
      @(negedge inClk);
      if (bus.outDone) seen = 1;
      else c++;
      if (toggle) bus.inDecipher = ~bus.inDecipher;
    end
    bus.inDecipher = 1'b0;
    check({name, "_done_cycle"}, 32'(c), 32'd19);
    @(posedge inClk);
    #1 check({name, "_ready_after"}, 32'(bus.outReady), 32'd1);
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    do_reset();
    #1 check_idle("reset");

    // encipher, decipher, decipher with mode input toggling during the op
    run_full("enc", 1'b0, 1'b0, 1'b0);
    run_full("dec", 1'b1, 1'b0, 1'b0);
    run_full("dec_toggle", 1'b1, 1'b0, 1'b1);

    // start held high: accepted at edges 0, 20, 40 only
    d0 = done_cnt;
    push_op(1'b0, 19); push_op(1'b0, 19); push_op(1'b0, 19);
    @(negedge inClk);
    bus.inStart = 1'b1;
    repeat (60) @(posedge inClk);
    #1 bus.inStart = 1'b0;
    check("held_done_count", 32'(done_cnt - d0), 32'd3);
    check_idle("held_end");

    // abort during round 7 (cycle 9)
    d0 = done_cnt;
    push_op(1'b0, 9);
    start_op(1'b0, 1'b0);
    repeat (8) @(posedge inClk);
    #1 check("abort_round_idx", 32'(bus.outRound), 32'd7);
    bus.inAbort = 1'b1;
    @(posedge inClk);
    #1 bus.inAbort = 1'b0;
    check_idle("abort");
    repeat (25) @(posedge inClk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // new start with abort also high in IDLE: start wins
    run_full("after_abort", 1'b0, 1'b1, 1'b0);

    // reset during round 12 (cycle 14)
    d0 = done_cnt;
    push_op(1'b1, 14);
    start_op(1'b1, 1'b0);
    repeat (13) @(posedge inClk);
    #1 check("rst_round_idx", 32'(bus.outRound), 32'd12);
    inRstN = 1'b0;
    @(posedge inClk);
    #1 check_idle("rst_mid");
    check("rst_mode", 32'(bus.outKeyDecipher), 32'd0);
    inRstN = 1'b1;
    repeat (25) @(posedge inClk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);

    run_full("after_rst", 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge inClk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
